// File: rtl/clock_counter.sv
// ---------------------------------------------------------------------------
// clock_counter
//
// Time-of-day timebase. Divides the system clock down to a 1 Hz tick and
// keeps hours, minutes and seconds as plain binary counters for the
// seven-segment decoder downstream. A two-button set mode lets the user
// adjust hours and then minutes. Every output comes straight from a
// register, so the decoder never sees glitches.
//
// Parameters:
//   CLK_HZ    system clock frequency in Hz (>= 2); one tick every CLK_HZ cycles
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst       asynchronous active-high reset
//   mode_btn  one-cycle pulse, advances RUN -> SET_H -> SET_M -> RUN
//   inc_btn   one-cycle pulse, increments the field being set
//   h         hours   (0..23, or 1..12 in 12-hour builds)
//   m         minutes (0..59)
//   s         seconds (0..59)
//   tick_1hz  one-cycle pulse at each second boundary while running
//   set_mode  0 = RUN, 1 = SET_H, 2 = SET_M
//   pm        afternoon flag (always 0 in 24-hour builds)
//
// Build option:
//   CLOCK_12H_EN  when defined, hours run 12,1..11 and pm toggles on 11 -> 12
// ---------------------------------------------------------------------------
module clock_counter #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [4:0] h,
    output logic [5:0] m,
    output logic [5:0] s,
    output logic       tick_1hz,
    output logic [1:0] set_mode,
    output logic       pm
);

    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SET_H = 2'd1;
    localparam logic [1:0] ST_SET_M = 2'd2;

`ifdef CLOCK_12H_EN
    localparam logic [4:0] H_RESET = 5'd12;
`else
    localparam logic [4:0] H_RESET = 5'd0;
`endif

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q,  tick_d;
    logic [4:0]    h_q,     h_d;
    logic [5:0]    m_q,     m_d;
    logic [5:0]    s_q,     s_d;
`ifdef CLOCK_12H_EN
    logic          pm_q,    pm_d;
`endif

    // Hour successor shared by the running carry and the SET_H button.
    function automatic logic [4:0] hour_inc(input logic [4:0] hr);
`ifdef CLOCK_12H_EN
        return (hr == 5'd12) ? 5'd1 : hr + 5'd1;
`else
        return (hr == 5'd23) ? 5'd0 : hr + 5'd1;
`endif
    endfunction

    function automatic logic [5:0] sixty_inc(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no
        // path through the case below can leave one unassigned (no latches).
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
`ifdef CLOCK_12H_EN
        pm_d    = pm_q;
`endif

        case (state_q)
            ST_RUN: begin
                if (mode_btn) begin
                    // Entering set mode freezes time immediately.
                    state_d = ST_SET_H;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    s_d     = sixty_inc(s_q);
                    // The whole seconds -> minutes -> hours carry chain
                    // resolves in this one edge, so 23:59:59 -> 00:00:00
                    // shows no intermediate values.
                    if (s_q == 6'd59) begin
                        m_d = sixty_inc(m_q);
                        if (m_q == 6'd59) begin
                            h_d = hour_inc(h_q);
`ifdef CLOCK_12H_EN
                            if (h_q == 5'd11) pm_d = ~pm_q;
`endif
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            ST_SET_H: begin
                presc_d = '0;
                if (mode_btn) begin
                    state_d = ST_SET_M;
                end else if (inc_btn) begin
                    h_d = hour_inc(h_q);
`ifdef CLOCK_12H_EN
                    if (h_q == 5'd11) pm_d = ~pm_q;
`endif
                end
            end

            ST_SET_M: begin
                presc_d = '0;
                if (mode_btn) begin
                    // Restart the minute cleanly: first tick comes a full
                    // CLK_HZ cycles after returning to RUN.
                    state_d = ST_RUN;
                    s_d     = '0;
                end else if (inc_btn) begin
                    m_d = sixty_inc(m_q);
                end
            end

            default: begin
                state_d = ST_RUN;
                presc_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            tick_q  <= 1'b0;
            h_q     <= H_RESET;
            m_q     <= '0;
            s_q     <= '0;
`ifdef CLOCK_12H_EN
            pm_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
`ifdef CLOCK_12H_EN
            pm_q    <= pm_d;
`endif
        end
    end

    assign h        = h_q;
    assign m        = m_q;
    assign s        = s_q;
    assign tick_1hz = tick_q;
    assign set_mode = state_q;
`ifdef CLOCK_12H_EN
    assign pm       = pm_q;
`else
    assign pm       = 1'b0;
`endif

endmodule
